inst_fetch: RTL
===============

# inst_fetch

Instruction fetch unit. Generates the PC, issues instruction-memory requests over a req/gnt/rvalid bus, and buffers returned instructions in a 2-entry FIFO. It presents one {instruction, address} pair per cycle to the IF/ID pipeline register. It honours the 3-bit pipeline hold code and EX-stage jump redirects, and inserts the flush NOP (32'h0000_0001) whenever no valid instruction is available.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- jump_en_i  in  1  redirect request from EX
- jump_addr_i  in  64  redirect target, 4-byte aligned
- pipe_hold_en_i  in  3  hold code: 0 = run; >=1 = no new requests; >=2 = IF/ID holding, do not pop FIFO
- if_req_o  out  1  memory request valid
- if_addr_o  out  64  request address
- if_gnt_i  in  1  request accepted this cycle
- if_rvalid_i  in  1  response valid; responses return in order
- if_rdata_i  in  32  response instruction
- inst_o  out  32  instruction to IF/ID
- inst_addr_o  out  64  instruction address to IF/ID

## Operation
- Registers:
  - pc (next fetch address)
  - req FSM {REQ_IDLE, REQ_PEND} with req_addr
  - outstanding count (0..2)
  - kill count (0..2)
  - 2-entry FIFO of {inst, addr}
- Occupancy = FIFO entries + outstanding, evaluated after this cycle's pop.
- REQ_IDLE → REQ_PEND when pipe_hold_en_i==0, occupancy<2 and jump_en_i==0.
  - Drive if_req_o=1 with if_addr_o=pc and latch req_addr=pc.
  - If if_gnt_i is high in the same cycle, the request completes that cycle: the FSM stays in REQ_IDLE, pc+=4, outstanding+=1.
- REQ_PEND: if_req_o and if_addr_o=req_addr stay stable until if_gnt_i, independent of hold or jump. On gnt: outstanding+=1, return to REQ_IDLE.
- Response handling on if_rvalid_i: outstanding-=1.
  - If kill count>0: discard the response, kill count-=1.
  - Otherwise push {if_rdata_i, address}. Addresses are tracked in a small in-order address queue alongside outstanding.
- Output: FIFO head if non-empty, else inst_o=32'h0000_0001, inst_addr_o=0.
  - Pop when pipe_hold_en_i<2 and FIFO non-empty.
- Redirect (jump_en_i=1), priority over hold:
  - Flush the FIFO.
  - inst_o forced to NOP, inst_addr_o forced to 0 this cycle.
  - pc ← jump_addr_i.
  - kill count ← outstanding after this cycle's gnt/rvalid updates, including a request granted this cycle.
  - No new request is issued in the redirect cycle.
  - A REQ_PEND request still completes and is killed.
- pc arithmetic is 64-bit modulo 2^64; wrap is silent.

## Timing
- Reset values:
  - if_req_o=0, if_addr_o=0
  - pc=RESET_PC
  - FIFO empty, outstanding=0, kill=0
  - inst_o=32'h0000_0001, inst_addr_o=0
- First request is asserted the first cycle after rst_n deasserts.
- Latency: request granted in cycle N, rvalid in N+1 → inst_o valid in N+2 (FIFO head is registered).
- Zero-wait memory sustains 1 instruction/cycle with hold=0.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Push when the FIFO is full and no pop is impossible by the occupancy rule; an assertion checks this.
- rvalid with outstanding==0 is a protocol error; an assertion checks this.
- rst_n asserted mid-transaction clears all state immediately. The memory side is reset by the same rst_n.

## Structure
- defines.v holds the shared constants: INST_WIDTH, ADDR_BUS_WIDTH, ZERO_WORD, INST_NOP (32'h0000_0001), the hold-code thresholds, and RESET_PC default.
- Sub-module fetch_fifo: 2-deep, width 96 {inst, addr}, with push/pop/flush/full/empty.
- The PC/request FSM and kill logic live in the top module.

## Test plan
- Reset release, gnt and rvalid always 1:
  - if_addr_o sequence 0x8000_0000, 0x8000_0004, …
  - inst_o shows the matching rdata starting cycle 3 after reset release.
  - One instruction per cycle.
- hold=3'b010 for 3 cycles mid-stream:
  - inst_o/inst_addr_o frozen.
  - At most 2 instructions buffered, no request while occupancy==2.
  - Stream resumes in order with no loss.
- hold=3'b001: no new requests issued; FIFO continues to drain to IF/ID; NOP appears once empty.
- jump_en_i with target 0x8000_0100 while 2 responses are outstanding:
  - Both responses discarded.
  - NOP output in the jump cycle.
  - Next request address is 0x8000_0100.
- gnt held low 4 cycles, then jump_en_i asserted during REQ_PEND:
  - if_addr_o remains the old address until gnt.
  - That response is killed.
  - Next fetch is the jump target.
- rst_n asserted while REQ_PEND with a full FIFO: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants, types and helpers for the instruction fetch unit.
package inst_fetch_pkg;

    localparam int INST_WIDTH     = 32;
    localparam int ADDR_BUS_WIDTH = 64;

    localparam logic [INST_WIDTH-1:0]     ZERO_WORD = 32'h0000_0000;
    localparam logic [INST_WIDTH-1:0]     INST_NOP  = 32'h0000_0001;
    localparam logic [ADDR_BUS_WIDTH-1:0] ZERO_ADDR = 64'h0000_0000_0000_0000;

    // hold code thresholds: >= NO_REQ stops requests, >= NO_POP also freezes IF/ID
    localparam logic [2:0] HOLD_NO_REQ = 3'd1;
    localparam logic [2:0] HOLD_NO_POP = 3'd2;

    localparam logic [ADDR_BUS_WIDTH-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [0:0] {
        REQ_IDLE = 1'b0,
        REQ_PEND = 1'b1
    } req_state_e;

    typedef struct packed {
        logic [INST_WIDTH-1:0]     inst;
        logic [ADDR_BUS_WIDTH-1:0] addr;
    } fetch_entry_t;

    function automatic logic [ADDR_BUS_WIDTH-1:0] next_pc(input logic [ADDR_BUS_WIDTH-1:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_chk.sv
// Protocol checks for the fetch unit's response port and buffer.
module inst_fetch_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       rvalid,
    input logic [1:0] outstanding,
    input logic       push,
    input logic       pop,
    input logic       full
);

    a_rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) rvalid |-> (outstanding != 2'd0));

    a_no_push_into_full: assert property (
        @(posedge clk) disable iff (!rst_n) (push && full) |-> pop);

endmodule

// File: rtl/inst_fetch_fifo.sv
// Two-entry {inst, addr} buffer between the memory response port and IF/ID.
module inst_fetch_fifo
    import inst_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    fetch_entry_t mem_r [2];
    logic         rd_ptr_r;
    logic         wr_ptr_r;
    logic [1:0]   count_r;
    logic         do_push_s;
    logic         do_pop_s;

    // qualify push/pop; a full FIFO accepts a push only alongside a pop
    always_comb begin
        do_pop_s  = pop && (count_r != 2'd0) && !flush;
        do_push_s = push && !flush && ((count_r != 2'd2) || do_pop_s);
    end

    // storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= '{inst: ZERO_WORD, addr: ZERO_ADDR};
            mem_r[1] <= '{inst: ZERO_WORD, addr: ZERO_ADDR};
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, do_push_s} - {1'b0, do_pop_s};
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == 2'd2);
    assign empty = (count_r == 2'd0);
    assign count = count_r;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC and request FSM, in-order response tracking with
// redirect kill, and a 2-entry buffer feeding the IF/ID register.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_BUS_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      jump_en_i,
    input  logic [ADDR_BUS_WIDTH-1:0] jump_addr_i,
    input  logic [2:0]                pipe_hold_en_i,
    output logic                      if_req_o,
    output logic [ADDR_BUS_WIDTH-1:0] if_addr_o,
    input  logic                      if_gnt_i,
    input  logic                      if_rvalid_i,
    input  logic [INST_WIDTH-1:0]     if_rdata_i,
    output logic [INST_WIDTH-1:0]     inst_o,
    output logic [ADDR_BUS_WIDTH-1:0] inst_addr_o
);

    req_state_e                state_r, state_s;
    logic                      started_r;
    logic [ADDR_BUS_WIDTH-1:0] pc_r, pc_s;
    logic [ADDR_BUS_WIDTH-1:0] req_addr_r, req_addr_s;
    logic [1:0]                outstanding_r, outstanding_s;
    logic [1:0]                kill_r, kill_s;
    logic [ADDR_BUS_WIDTH-1:0] aq_r [2];
    logic [ADDR_BUS_WIDTH-1:0] aq_s [2];
    logic [1:0]                aq_idx_s;

    logic                      issue_s;
    logic                      req_valid_s;
    logic [ADDR_BUS_WIDTH-1:0] req_out_addr_s;
    logic                      gnt_take_s;
    logic                      pend_after_s;
    logic [2:0]                occupancy_s;

    logic                      push_s;
    logic                      pop_s;
    fetch_entry_t              fifo_wdata_s;
    fetch_entry_t              fifo_head_s;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic [1:0]                fifo_count_s;

    // request generation, PC/FSM next state, outstanding and kill bookkeeping
    always_comb begin
        state_s        = state_r;
        pc_s           = pc_r;
        req_addr_s     = req_addr_r;
        kill_s         = kill_r;
        aq_s[0]        = aq_r[0];
        aq_s[1]        = aq_r[1];
        pop_s          = !jump_en_i && (pipe_hold_en_i < HOLD_NO_POP) && !fifo_empty_s;
        occupancy_s    = {1'b0, fifo_count_s} - {2'b00, pop_s} + {1'b0, outstanding_r};
        issue_s        = started_r && (state_r == REQ_IDLE) && (pipe_hold_en_i < HOLD_NO_REQ)
                         && (occupancy_s < 3'd2) && !jump_en_i;
        req_valid_s    = issue_s || (state_r == REQ_PEND);
        req_out_addr_s = (state_r == REQ_PEND) ? req_addr_r : pc_r;
        gnt_take_s     = req_valid_s && if_gnt_i;
        pend_after_s   = (state_r == REQ_PEND) && !if_gnt_i;
        outstanding_s  = outstanding_r + {1'b0, gnt_take_s} - {1'b0, if_rvalid_i};
        push_s         = if_rvalid_i && (kill_r == 2'd0) && !jump_en_i;
        fifo_wdata_s   = '{inst: if_rdata_i, addr: aq_r[0]};

        case (state_r)
            REQ_IDLE: begin
                if (issue_s) begin
                    pc_s       = next_pc(pc_r);
                    req_addr_s = pc_r;
                    state_s    = if_gnt_i ? REQ_IDLE : REQ_PEND;
                end else begin
                    state_s = REQ_IDLE;
                end
            end
            REQ_PEND: begin
                if (if_gnt_i) begin
                    state_s = REQ_IDLE;
                end else begin
                    state_s = REQ_PEND;
                end
            end
            default: begin
                state_s = REQ_IDLE;
            end
        endcase

        // a redirect kills everything in flight, including a still-pending request
        if (jump_en_i) begin
            pc_s   = jump_addr_i;
            kill_s = outstanding_s + {1'b0, pend_after_s};
        end else if (if_rvalid_i && (kill_r != 2'd0)) begin
            kill_s = kill_r - 2'd1;
        end else begin
            kill_s = kill_r;
        end

        aq_idx_s = outstanding_r - {1'b0, if_rvalid_i};
        if (if_rvalid_i) begin
            aq_s[0] = aq_r[1];
        end else begin
            aq_s[0] = aq_r[0];
        end
        if (gnt_take_s) begin
            aq_s[aq_idx_s[0]] = req_out_addr_s;
        end else begin
            aq_idx_s = aq_idx_s;
        end
    end

    // fetch control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= REQ_IDLE;
            started_r     <= 1'b0;
            pc_r          <= RESET_PC;
            req_addr_r    <= ZERO_ADDR;
            outstanding_r <= 2'd0;
            kill_r        <= 2'd0;
            aq_r[0]       <= ZERO_ADDR;
            aq_r[1]       <= ZERO_ADDR;
        end else begin
            state_r       <= state_s;
            started_r     <= 1'b1;
            pc_r          <= pc_s;
            req_addr_r    <= req_addr_s;
            outstanding_r <= outstanding_s;
            kill_r        <= kill_s;
            aq_r[0]       <= aq_s[0];
            aq_r[1]       <= aq_s[1];
        end
    end

    // bus and IF/ID outputs; NOP whenever nothing valid is presented
    always_comb begin
        if_req_o  = req_valid_s;
        if_addr_o = req_valid_s ? req_out_addr_s : ZERO_ADDR;
        if (jump_en_i || fifo_empty_s) begin
            inst_o      = INST_NOP;
            inst_addr_o = ZERO_ADDR;
        end else begin
            inst_o      = fifo_head_s.inst;
            inst_addr_o = fifo_head_s.addr;
        end
    end

    inst_fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (jump_en_i),
        .wdata (fifo_wdata_s),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    inst_fetch_chk u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .rvalid      (if_rvalid_i),
        .outstanding (outstanding_r),
        .push        (push_s),
        .pop         (pop_s),
        .full        (fifo_full_s)
    );

endmodule
